rgb_frame_reader: RTL and testbench



---
 rtl/rgb_frame_reader_pkg.sv | 12 +
 rtl/rgb_word_fifo.sv | 49 ++++
 rtl/rgb_frame_reader.sv | 183 ++++++++++++++++++
 tb/tb_rgb_frame_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_frame_reader_pkg.sv
// Shared constants and FSM state type for the RGB frame reader.
// Frame geometry defaults describe the 320x240 packed RGB frame in SRAM.
package rgb_frame_reader_pkg;
  localparam logic [17:0] RGB_BASE            = 18'd146944;
  localparam int          IMG_W               = 320;
  localparam int          IMG_H               = 240;
  localparam int          RGB_WORDS_PER_FRAME = IMG_W * IMG_H * 3 / 2;
  localparam int          SRAM_RD_LAT         = 2;
  localparam int          WFIFO_DEPTH         = 8;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} rgb_rd_state_type;
endpackage

// File: rtl/rgb_word_fifo.sv
// 16-bit first-word-fall-through FIFO with occupancy count.
// rd_data_o always shows the oldest entry while the FIFO is not empty.
module rgb_word_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [15:0]   wr_data_i,
  input  logic          rd_en_i,
  output logic [15:0]   rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_wr, do_rd;

  assign do_rd = rd_en_i && (count_q != '0);
  assign do_wr = wr_en_i && ((count_q != CW'(DEPTH)) || do_rd);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

  // Upstream credit accounting must never let a word arrive into a full FIFO.
  assert property (@(posedge clk_i) disable iff (!rst_n_i)
                   !(wr_en_i && (count_q == CW'(DEPTH)) && !rd_en_i));
endmodule

// File: rtl/rgb_frame_reader.sv
// Streams a packed 8-bit RGB frame ({R0,G0},{B0,R1},{G1,B1} per pixel pair)
// from SRAM and presents one pixel per valid/ready handshake.
module rgb_frame_reader
  import rgb_frame_reader_pkg::*;
#(
  parameter logic [17:0] FRAME_BASE = RGB_BASE,
  parameter int          FRAME_W    = IMG_W,
  parameter int          FRAME_H    = IMG_H
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        sof,
  output logic        eol
);
  localparam int FRAME_WORDS = FRAME_W * FRAME_H * 3 / 2;
  localparam int CW          = $clog2(WFIFO_DEPTH) + 1;

  rgb_rd_state_type       state_q, state_d;
  logic [17:0]            addr_q, addr_d, issued_q, issued_d;
  logic [SRAM_RD_LAT-1:0] vld_q, vld_d;
  logic [1:0]             phase_q, phase_d;
  logic [15:0]            rg_q, rg_d;
  logic [7:0]             r1_q, r1_d, r_q, r_d, g_q, g_d, b_q, b_d;
  logic                   pv_q, pv_d;
  logic [9:0]             x_q, x_d, y_q, y_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [15:0]   fifo_data;
  logic          rd_en, pop, hs, last_pix, out_free, frame_active;
  int            inflight;

  rgb_word_fifo #(.DEPTH(WFIFO_DEPTH), .CW(CW)) u_fifo (
    .clk_i    (CLOCK_50_I),
    .rst_n_i  (resetn),
    .wr_en_i  (vld_q[SRAM_RD_LAT-1]),
    .wr_data_i(SRAM_read_data),
    .rd_en_i  (pop),
    .rd_data_o(fifo_data),
    .count_o  (fifo_count),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    inflight = 0;
    for (int i = 0; i < SRAM_RD_LAT; i++) inflight += int'(vld_q[i]);
  end

  // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
  // once raised, pix_valid and the pixel fields hold until that transfer.
  always_comb begin
    hs           = pv_q && pix_ready;
    last_pix     = hs && (x_q == 10'(FRAME_W - 1)) && (y_q == 10'(FRAME_H - 1));
    out_free     = !pv_q || pix_ready;
    frame_active = (state_q == S_FETCH) || (state_q == S_DRAIN);
    rd_en        = (state_q == S_FETCH) && ((int'(fifo_count) + inflight) < WFIFO_DEPTH);
    pop          = frame_active && !fifo_empty && out_free;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    issued_d = issued_q;
    vld_d    = {vld_q[SRAM_RD_LAT-2:0], rd_en};
    phase_d  = phase_q;
    rg_d     = rg_q;
    r1_d     = r1_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    pv_d     = pv_q;
    x_d      = x_q;
    y_d      = y_q;

    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_FETCH;
        addr_d   = FRAME_BASE;
        issued_d = '0;
        phase_d  = 2'd0;
        x_d      = '0;
        y_d      = '0;
      end
      S_FETCH: if (rd_en) begin
        issued_d = issued_q + 18'd1;
        // The final address is held rather than incremented so it never wraps.
        if (issued_q == 18'(FRAME_WORDS - 1)) state_d = S_DRAIN;
        else                                  addr_d  = addr_q + 18'd1;
      end
      S_DRAIN: ;
      default: state_d = S_IDLE;
    endcase
    if (last_pix) state_d = S_DONE;

    if (pop) begin
      case (phase_q)
        2'd0: begin
          rg_d    = fifo_data;
          phase_d = 2'd1;
        end
        2'd1: begin
          r_d     = rg_q[15:8];
          g_d     = rg_q[7:0];
          b_d     = fifo_data[15:8];
          r1_d    = fifo_data[7:0];
          phase_d = 2'd2;
        end
        default: begin
          r_d     = r1_q;
          g_d     = fifo_data[15:8];
          b_d     = fifo_data[7:0];
          phase_d = 2'd0;
        end
      endcase
    end

    if (pop && (phase_q != 2'd0)) pv_d = 1'b1;
    else if (hs)                  pv_d = 1'b0;

    if (hs) begin
      if (x_q == 10'(FRAME_W - 1)) begin
        x_d = '0;
        y_d = (y_q == 10'(FRAME_H - 1)) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= FRAME_BASE;
      issued_q <= '0;
      vld_q    <= '0;
      phase_q  <= 2'd0;
      rg_q     <= '0;
      r1_q     <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      pv_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
      vld_q    <= vld_d;
      phase_q  <= phase_d;
      rg_q     <= rg_d;
      r1_q     <= r1_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      pv_q     <= pv_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign busy         = frame_active;
  assign done         = (state_q == S_DONE);
  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign pix_valid    = pv_q;
  assign R            = r_q;
  assign G            = g_q;
  assign B            = b_q;
  assign sof          = pv_q && (x_q == 10'd0) && (y_q == 10'd0);
  assign eol          = pv_q && (x_q == 10'(FRAME_W - 1));
endmodule

// File: tb/tb_rgb_frame_reader.sv
// Bench for rgb_frame_reader on a reduced 16x8 frame placed at the top of SRAM
// so the final word lands on address 262143.
module tb_rgb_frame_reader;
  import rgb_frame_reader_pkg::*;

  localparam int          TW     = 16;
  localparam int          TH     = 8;
  localparam int          NPIX   = TW * TH;
  localparam int          NWORDS = NPIX * 3 / 2;
  localparam logic [17:0] TBASE  = 18'(262144 - NWORDS);
  localparam logic [17:0] TLAST  = 18'd262143;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic pix_ready = 1'b0;
  logic busy, done, SRAM_we_n, pix_valid, sof, eol;
  logic [17:0] SRAM_address;
  logic [15:0] sram_rd = 16'h0;
  logic [7:0]  R, G, B;

  always #10 clk = ~clk;

  rgb_frame_reader #(.FRAME_BASE(TBASE), .FRAME_W(TW), .FRAME_H(TH)) dut (
    .CLOCK_50_I    (clk),
    .resetn        (resetn),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(sram_rd),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .R             (R),
    .G             (G),
    .B             (B),
    .sof           (sof),
    .eol           (eol)
  );

  // SRAM model: data for the address seen in cycle k is presented in cycle k+2
  logic [15:0] mem [NWORDS];
  logic [15:0] d1 = 16'h0, d2 = 16'h0;

  function automatic logic [15:0] sram_lookup(input logic [17:0] a);
    int idx;
    idx = int'(a) - int'(TBASE);
    if (idx >= 0 && idx < NWORDS) return mem[idx];
    return 16'hDEAD;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      sram_rd = d2;
      d2      = d1;
      d1      = sram_lookup(SRAM_address);
    end
  end

  // ready driver: 0 always, 1 one-in-three, 2 random, 3 held low
  int ready_mode = 0;
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (cyc % 3 == 0);
        2:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // scoreboard
  logic [25:0] exp_q[$];
  int checks = 0, failures = 0;
  int hs_cnt = 0, eol_cnt = 0, done_cnt = 0, cyc_cnt = 0;
  logic [17:0] max_addr = '0, min_addr = '1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // reference model: pixel pair p is built from words 3p..3p+2 of the frame
  task automatic push_frame();
    for (int p = 0; p < NPIX / 2; p++) begin
      logic [15:0] w0, w1, w2;
      int px;
      w0 = mem[3*p];
      w1 = mem[3*p+1];
      w2 = mem[3*p+2];
      px = 2 * p;
      exp_q.push_back({px == 0, (px % TW) == TW - 1, w0[15:8], w0[7:0], w1[15:8]});
      exp_q.push_back({1'b0, ((px + 1) % TW) == TW - 1, w1[7:0], w2[15:8], w2[7:0]});
    end
  endtask

  // monitor
  initial begin
    logic        hold_prev;
    logic [25:0] prev, got, exp;
    hold_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        hold_prev = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      if (busy && SRAM_address > max_addr) max_addr = SRAM_address;
      if (busy && SRAM_address < min_addr) min_addr = SRAM_address;
      got = {sof, eol, R, G, B};
      if (hold_prev) begin
        check("hold_valid", 32'(pix_valid), 32'd1);
        check("hold_data", 32'(got), 32'(prev));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'(got), 32'h3FFFFFF);
        end else begin
          exp = exp_q.pop_front();
          check("pixel", 32'(got), 32'(exp));
        end
        hs_cnt++;
        if (eol) eol_cnt++;
      end
      hold_prev = pix_valid && !pix_ready;
      prev      = got;
    end
  end

  // driver tasks
  task automatic fill_mem();
    for (int i = 0; i < NWORDS; i++) mem[i] = 16'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  int start_cyc = 0;
  task automatic start_frame();
    hs_cnt   = 0;
    eol_cnt  = 0;
    done_cnt = 0;
    max_addr = '0;
    min_addr = '1;
    push_frame();
    pulse_start();
    start_cyc = cyc_cnt;
  endtask

  task automatic wait_done(input string t, output int cycles);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({t, "_done_seen"}, 32'(done), 32'd1);
    cycles = cyc_cnt - start_cyc;
  endtask

  task automatic reset_checks(input string t);
    check({t, "_rst_busy"}, 32'(busy), 32'd0);
    check({t, "_rst_done"}, 32'(done), 32'd0);
    check({t, "_rst_addr"}, 32'(SRAM_address), 32'(TBASE));
    check({t, "_rst_we_n"}, 32'(SRAM_we_n), 32'd1);
    check({t, "_rst_valid"}, 32'(pix_valid), 32'd0);
    check({t, "_rst_rgb"}, 32'({R, G, B}), 32'd0);
    check({t, "_rst_sof_eol"}, 32'({sof, eol}), 32'd0);
  endtask

  task automatic frame_end_checks(input string t);
    repeat (3) @(negedge clk);
    check({t, "_handshakes"}, 32'(hs_cnt), 32'(NPIX));
    check({t, "_eol_count"}, 32'(eol_cnt), 32'(TH));
    check({t, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({t, "_busy_after"}, 32'(busy), 32'd0);
    check({t, "_final_addr"}, 32'(SRAM_address), 32'(TLAST));
    check({t, "_max_addr"}, 32'(max_addr), 32'(TLAST));
    check({t, "_min_addr"}, 32'(min_addr), 32'(TBASE));
    check({t, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({t, "_we_n"}, 32'(SRAM_we_n), 32'd1);
  endtask

  // main sequence
  initial begin
    int lat, n, ref_cycles, cycles, changes;
    logic [17:0] a_prev, a_mid;

    repeat (2) @(negedge clk);
    reset_checks("init");
    @(posedge clk);
    #1 resetn = 1'b1;

    // 1) first pixels and first-pixel latency
    ready_mode = 0;
    fill_mem();
    mem[0] = 16'h0A0B;
    mem[1] = 16'h0C1A;
    mem[2] = 16'h1B1C;
    start_frame();
    lat = 1;
    @(negedge clk);
    while (!pix_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency_ok", 32'(lat <= SRAM_RD_LAT + 4), 32'd1);
    check("t1_pix0", 32'({sof, eol, R, G, B}), 32'({1'b1, 1'b0, 24'h0A0B0C}));
    wait_done("t1", cycles);
    frame_end_checks("t1");

    // 2) full frame at full rate
    fill_mem();
    start_frame();
    wait_done("t2", ref_cycles);
    frame_end_checks("t2");

    // 3) consumer accepts one cycle in three, then random acceptance
    ready_mode = 1;
    fill_mem();
    start_frame();
    wait_done("t3", cycles);
    frame_end_checks("t3");
    ready_mode = 2;
    fill_mem();
    start_frame();
    wait_done("t3r", cycles);
    frame_end_checks("t3r");

    // 4) long stall after the first valid pixel
    ready_mode = 0;
    fill_mem();
    start_frame();
    n = 0;
    while (!pix_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_valid_seen", 32'(pix_valid), 32'd1);
    ready_mode = 3;
    a_prev  = SRAM_address;
    a_mid   = SRAM_address;
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (SRAM_address != a_prev) changes++;
      a_prev = SRAM_address;
      if (i == 50) a_mid = SRAM_address;
    end
    check("t4_reads_bounded", 32'(changes <= WFIFO_DEPTH), 32'd1);
    check("t4_addr_frozen", 32'(SRAM_address), 32'(a_mid));
    ready_mode = 0;
    wait_done("t4", cycles);
    frame_end_checks("t4");

    // 5) reset mid-frame, then restart with new frame contents
    fill_mem();
    start_frame();
    n = 0;
    while (hs_cnt < 50 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_px", 32'(hs_cnt >= 50), 32'd1);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    reset_checks("t5");
    exp_q.delete();
    fill_mem();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    start_frame();
    wait_done("t5", cycles);
    frame_end_checks("t5");

    // 6) start pulses while busy are ignored
    fill_mem();
    start_frame();
    repeat (20) @(negedge clk);
    pulse_start();
    @(negedge clk);
    check("t6_busy_kept", 32'(busy), 32'd1);
    repeat (37) @(negedge clk);
    pulse_start();
    wait_done("t6", cycles);
    check("t6_done_timing", 32'(cycles), 32'(ref_cycles));
    frame_end_checks("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
